// File: rtl/cen_subtractor_n.sv
// cen_subtractor_n: per-channel frame centring engine.
// Pass 1 (ACCUM) sums 2^LOG2_LEN unsigned samples per channel and latches the floor mean.
// Pass 2 (SUBTR) subtracts the latched mean from the replayed frame and emits signed
// results, clamped to the W-bit signed range when SAT=1 or wrapped to W bits when SAT=0.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   GO                   one-cycle frame start, honoured only while idle
//   in_valid/in_ready    input handshake, in_data holds CH packed W-bit unsigned samples
//   out_valid/out_ready  output handshake, out_data holds CH packed W-bit signed results
//   mean_out/mean_valid  latched per-channel means for the current frame
//   busy                 high whenever a frame is in progress
//   done                 pulses on the handshake that drains the last result
module cen_subtractor_n #(
    parameter int unsigned CH       = 4,
    parameter int unsigned W        = 26,
    parameter int unsigned LOG2_LEN = 10,
    parameter bit          SAT      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            GO,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_data,
    output logic [CH*W-1:0] mean_out,
    output logic            mean_valid,
    output logic            busy,
    output logic            done
);

    localparam int unsigned AccW = W + LOG2_LEN;

    typedef enum logic [1:0] {StIdle, StAccum, StSubtr} state_e;

    state_e                state_q, state_d;
    logic [AccW-1:0]       acc_q [CH];
    logic [AccW-1:0]       acc_d [CH];
    logic [AccW-1:0]       sum   [CH];
    logic [LOG2_LEN-1:0]   cnt_q, cnt_d;
    logic [CH*W-1:0]       mean_q, mean_d;
    logic [CH*W-1:0]       out_q, out_d;
    logic [CH*W-1:0]       res;
    logic                  mean_valid_q, mean_valid_d;
    logic                  out_valid_q, out_valid_d;
    logic                  last_in_q, last_in_d;   // every replay sample has been taken
    logic                  in_hs, out_hs, cnt_last;

    // Per-channel running sum and centred result.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            logic [W:0] diff;
            sum[c] = acc_q[c] + AccW'(in_data[c*W +: W]);
            // Both operands zero-extended, so the W+1-bit result is the exact signed difference.
            diff = {1'b0, in_data[c*W +: W]} - {1'b0, mean_q[c*W +: W]};
            if (SAT && (diff[W] != diff[W-1])) begin
                res[c*W +: W] = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                res[c*W +: W] = diff[W-1:0];
            end
        end
    end

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StAccum: in_ready = 1'b1;
            StSubtr: in_ready = !last_in_q && (!out_valid_q || out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign cnt_last = (cnt_q == {LOG2_LEN{1'b1}});

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mean_d       = mean_q;
        out_d        = out_q;
        mean_valid_d = mean_valid_q;
        out_valid_d  = out_valid_q;
        last_in_d    = last_in_q;
        done         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (GO) begin
                    for (int c = 0; c < CH; c++) acc_d[c] = '0;
                    cnt_d        = '0;
                    mean_valid_d = 1'b0;
                    last_in_d    = 1'b0;
                    state_d      = StAccum;
                end
            end
            StAccum: begin
                if (in_hs) begin
                    for (int c = 0; c < CH; c++) acc_d[c] = sum[c];
                    if (cnt_last) begin
                        for (int c = 0; c < CH; c++) mean_d[c*W +: W] = sum[c][LOG2_LEN +: W];
                        mean_valid_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = StSubtr;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StSubtr: begin
                if (out_hs) out_valid_d = 1'b0;
                // A new result in the same cycle replaces the drained one.
                if (in_hs) begin
                    out_valid_d = 1'b1;
                    out_d       = res;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_last) last_in_d = 1'b1;
                end
                if (last_in_q && out_hs) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            for (int c = 0; c < CH; c++) acc_q[c] <= '0;
            cnt_q        <= '0;
            mean_q       <= '0;
            out_q        <= '0;
            mean_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            last_in_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mean_q       <= mean_d;
            out_q        <= out_d;
            mean_valid_q <= mean_valid_d;
            out_valid_q  <= out_valid_d;
            last_in_q    <= last_in_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_q;
    assign mean_out   = mean_q;
    assign mean_valid = mean_valid_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cen_subtractor_n.sv
// Bench for cen_subtractor_n with CH=2, W=8, LOG2_LEN=2. A saturating and a wrapping
// instance share all inputs so every frame exercises both result modes.
module tb_cen_subtractor_n;

    logic        clk = 1'b0;
    logic        rst, go, in_valid, out_ready;
    logic [15:0] in_data;
    logic        s_in_ready, s_out_valid, s_mean_valid, s_busy, s_done;
    logic [15:0] s_out_data, s_mean;
    logic        w_in_ready, w_out_valid, w_mean_valid, w_busy, w_done;
    logic [15:0] w_out_data, w_mean;

    int total = 0;
    int bad   = 0;

    typedef logic [3:0][7:0] frm_t;
    typedef struct {
        frm_t       a0, a1, b0, b1;  // pass-1 and replay samples per channel
        logic [7:0] m0;              // expected ch0 mean
        frm_t       es, ew;          // expected ch0 results, saturating / wrapping
        int         mode;            // 0 free-flowing, 1 three-cycle stall, 2 random
        bit         gomid;
        bit         junk;            // drive in_valid while idle first
    } vec_t;

    vec_t tbl[6];
    logic [7:0] rs0[$], rs1[$], rw0[$], rw1[$];

    always #5 clk = ~clk;

    cen_subtractor_n #(.CH(2), .W(8), .LOG2_LEN(2), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .GO(go), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .mean_out(s_mean), .mean_valid(s_mean_valid),
        .busy(s_busy), .done(s_done)
    );

    cen_subtractor_n #(.CH(2), .W(8), .LOG2_LEN(2), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .GO(go), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .mean_out(w_mean), .mean_valid(w_mean_valid),
        .busy(w_busy), .done(w_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] ref_out(input int x, input int m, input bit sat);
        int d;
        d = x - m;
        if (sat) begin
            if (d > 127)  d = 127;
            if (d < -128) d = -128;
        end
        return 8'(d);
    endfunction

    function automatic int frame_mean(input frm_t f);
        return (int'(f[0]) + int'(f[1]) + int'(f[2]) + int'(f[3])) / 4;
    endfunction

    task automatic set_vec(input int idx, input frm_t a0, input frm_t a1, input frm_t b0,
                           input frm_t b1, input logic [7:0] m0, input frm_t es,
                           input frm_t ew, input int mode, input bit gomid, input bit junk);
        tbl[idx].a0 = a0; tbl[idx].a1 = a1; tbl[idx].b0 = b0; tbl[idx].b1 = b1;
        tbl[idx].m0 = m0; tbl[idx].es = es; tbl[idx].ew = ew;
        tbl[idx].mode = mode; tbl[idx].gomid = gomid; tbl[idx].junk = junk;
    endtask

    // Entered and left on a negedge; GO is raised immediately.
    task automatic run_frame(input frm_t a0, input frm_t a1, input frm_t b0, input frm_t b1,
                             input int mode, input bit gomid);
        int m0, m1, i, cyc, stall_left;
        bit done_seen, mean_pending, stalled, have_held;
        logic [15:0] held;
        m0 = frame_mean(a0);
        m1 = frame_mean(a1);
        rs0.delete(); rs1.delete(); rw0.delete(); rw1.delete();
        go = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("go_busy", int'(s_busy), 1);
        chk("go_in_ready", int'(s_in_ready), 1);
        chk("go_mean_valid_clr", int'(s_mean_valid), 0);
        i = 0; cyc = 0; stall_left = 0;
        done_seen = 0; mean_pending = 0; stalled = 0; have_held = 0; held = '0;
        while (!done_seen && cyc < 200) begin
            if (mean_pending) begin
                chk("mean_valid_set", int'(s_mean_valid), 1);
                chk("mean_ch0", int'(s_mean[7:0]), m0);
                chk("mean_ch1", int'(s_mean[15:8]), m1);
                chk("mean_ch0_w", int'(w_mean[7:0]), m0);
                mean_pending = 0;
            end
            go = gomid && (i == 1);
            in_valid = (i < 8) && (mode != 2 || $urandom_range(0, 3) != 0);
            if (i < 4)      in_data = {a1[i], a0[i]};
            else if (i < 8) in_data = {b1[i-4], b0[i-4]};
            else            in_data = '0;
            if (mode == 1) begin
                if (rs0.size() == 1 && !stalled) begin
                    stalled = 1; stall_left = 3;
                end
                out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (mode == 2) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (s_out_valid && !out_ready) begin
                chk("bp_in_ready", int'(s_in_ready), 0);
                if (have_held) chk("bp_hold", int'(s_out_data), int'(held));
                held = s_out_data; have_held = 1;
            end else begin
                have_held = 0;
            end
            if (s_out_valid && out_ready) begin
                rs0.push_back(s_out_data[7:0]); rs1.push_back(s_out_data[15:8]);
                rw0.push_back(w_out_data[7:0]); rw1.push_back(w_out_data[15:8]);
            end
            if (s_done) done_seen = 1;
            if (in_valid && s_in_ready) begin
                if (i == 3) mean_pending = 1;
                i++;
            end
            cyc++;
            @(negedge clk);
        end
        go = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("done_seen", int'(done_seen), 1);
        chk("busy_after_done", int'(s_busy), 0);
        chk("done_single", int'(s_done), 0);
        chk("inputs_used", i, 8);
        chk("mean_valid_hold", int'(s_mean_valid), 1);
        chk("out_count", rs0.size(), 4);
        if (rs0.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("out_s0", int'(rs0[k]), int'(ref_out(int'(b0[k]), m0, 1'b1)));
                chk("out_s1", int'(rs1[k]), int'(ref_out(int'(b1[k]), m1, 1'b1)));
                chk("out_w0", int'(rw0[k]), int'(ref_out(int'(b0[k]), m0, 1'b0)));
                chk("out_w1", int'(rw1[k]), int'(ref_out(int'(b1[k]), m1, 1'b0)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        frm_t ra0, ra1, rb0, rb1;
        int hs;
        rst = 1'b1; go = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

        set_vec(0, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd4, 8'd4, 8'd4},
                   {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd4, 8'd4, 8'd4}, 8'd25,
                   {8'h0F, 8'h05, 8'hFB, 8'hF1}, {8'h0F, 8'h05, 8'hFB, 8'hF1}, 0, 0, 1);
        set_vec(1, {8'd2, 8'd2, 8'd2, 8'd1}, {8'd9, 8'd0, 8'd3, 8'd7},
                   {8'd2, 8'd2, 8'd2, 8'd1}, {8'd9, 8'd0, 8'd3, 8'd7}, 8'd1,
                   {8'd1, 8'd1, 8'd1, 8'd0}, {8'd1, 8'd1, 8'd1, 8'd0}, 0, 0, 0);
        set_vec(2, {8'd255, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0},
                   {8'd255, 8'd63, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd63,
                   {8'h7F, 8'h00, 8'hC1, 8'h7F}, {8'hC0, 8'h00, 8'hC1, 8'hC0}, 0, 0, 0);
        set_vec(3, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd0},
                   {8'd128, 8'd255, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd255,
                   {8'h81, 8'h00, 8'h80, 8'h80}, {8'h81, 8'h00, 8'h01, 8'h01}, 0, 0, 0);
        set_vec(4, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd4, 8'd4, 8'd4},
                   {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd4, 8'd4, 8'd4}, 8'd25,
                   {8'h0F, 8'h05, 8'hFB, 8'hF1}, {8'h0F, 8'h05, 8'hFB, 8'hF1}, 1, 0, 0);
        set_vec(5, {8'd2, 8'd2, 8'd2, 8'd1}, {8'd8, 8'd8, 8'd8, 8'd8},
                   {8'd2, 8'd2, 8'd2, 8'd1}, {8'd8, 8'd8, 8'd8, 8'd8}, 8'd1,
                   {8'd1, 8'd1, 8'd1, 8'd0}, {8'd1, 8'd1, 8'd1, 8'd0}, 0, 1, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", int'(s_in_ready), 0);
        chk("rst_out_valid", int'(s_out_valid), 0);
        chk("rst_out_data", int'(s_out_data), 0);
        chk("rst_mean", int'(s_mean), 0);
        chk("rst_mean_valid", int'(s_mean_valid), 0);
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_done", int'(s_done), 0);

        // Directed vectors, run back to back: each GO lands on the cycle after done.
        for (int v = 0; v < 6; v++) begin
            if (tbl[v].junk) begin
                for (int j = 0; j < 3; j++) begin
                    in_valid = 1'b1; in_data = 16'hC8C8;
                    #1;
                    chk("idle_in_ready", int'(s_in_ready), 0);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            run_frame(tbl[v].a0, tbl[v].a1, tbl[v].b0, tbl[v].b1, tbl[v].mode, tbl[v].gomid);
            chk("tbl_mean0", int'(s_mean[7:0]), int'(tbl[v].m0));
            if (rs0.size() == 4) begin
                for (int k = 0; k < 4; k++) begin
                    chk("tbl_sat0", int'(rs0[k]), int'(tbl[v].es[k]));
                    chk("tbl_wrap0", int'(rw0[k]), int'(tbl[v].ew[k]));
                end
            end
        end

        // Reset mid-frame after the second replay handshake.
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        hs = 0;
        for (int c = 0; c < 50 && hs < 6; c++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h3377;
            #1;
            if (s_in_ready) hs++;
            @(negedge clk);
        end
        chk("rst_mid_handshakes", hs, 6);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(s_out_valid), 0);
        chk("mid_rst_out_data", int'(s_out_data), 0);
        chk("mid_rst_mean", int'(s_mean), 0);
        chk("mid_rst_mean_valid", int'(s_mean_valid), 0);
        chk("mid_rst_busy", int'(s_busy), 0);
        chk("mid_rst_in_ready", int'(s_in_ready), 0);
        chk("mid_rst_w_out_data", int'(w_out_data), 0);
        run_frame(tbl[0].a0, tbl[0].a1, tbl[0].b0, tbl[0].b1, 0, 0);

        // Random frames with random input gaps and backpressure.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 4; k++) begin
                ra0[k] = 8'($urandom); ra1[k] = 8'($urandom);
                rb0[k] = ($urandom_range(0, 1) != 0) ? ra0[k] : 8'($urandom);
                rb1[k] = 8'($urandom);
            end
            run_frame(ra0, ra1, rb0, rb1, 2, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
